// File: rtl/step_pkg.sv
// Shared FSM state encoding and default widths for the step/ramp generator.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL
  } state_e;

  localparam int unsigned DEF_STEP_W   = 32;
  localparam int unsigned DEF_PERIOD_W = 24;

endpackage

// File: rtl/step_pulse_timer.sv
// Per-step period counter: fixed-width step pulse at the start of each period
// and a boundary strobe during the last cycle of the period.
module step_pulse_timer #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned PULSE_W  = 4
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                active_i,
  input  logic                run_i,
  input  logic                restart_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                step_o,
  output logic                boundary_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                step_q, step_d;

  assign boundary_o = active_i && (cnt_q == period_i - PERIOD_W'(1));

  always_comb begin
    cnt_d = cnt_q + PERIOD_W'(1);
    if (!run_i || restart_i || boundary_o) begin
      cnt_d = '0;
    end
    // Pulse is high for the first PULSE_W cycles of every period that will run.
    step_d = run_i && (cnt_d < PERIOD_W'(PULSE_W));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/step_ramp_gen.sv
// Trapezoidal step generator: FSM and period/ramp arithmetic around a
// step_pulse_timer that produces the pulses and period boundaries.
module step_ramp_gen
  import step_pkg::*;
#(
  parameter int unsigned STEP_W     = DEF_STEP_W,
  parameter int unsigned PERIOD_W   = DEF_PERIOD_W,
  parameter int unsigned PERIOD_MAX = 100,
  parameter int unsigned PERIOD_MIN = 40,
  parameter int unsigned PERIOD_DEC = 20,
  parameter int unsigned PULSE_W    = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic [STEP_W-1:0] steps_i,
  input  logic              dir_i,
  input  logic              stop_i,
  output logic              step_o,
  output logic              dir_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [STEP_W-1:0] steps_left_o
);

  if (!(PULSE_W < PERIOD_MIN && PERIOD_MIN <= PERIOD_MAX && PERIOD_DEC > 0)) begin : g_param_check
    $error("step_ramp_gen: require PULSE_W < PERIOD_MIN <= PERIOD_MAX and PERIOD_DEC > 0");
  end

  localparam logic [PERIOD_W-1:0] P_MAX = PERIOD_W'(PERIOD_MAX);
  localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(PERIOD_MIN);
  localparam logic [PERIOD_W-1:0] P_DEC = PERIOD_W'(PERIOD_DEC);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   steps_left_q, steps_left_d;
  logic [STEP_W-1:0]   ramp_q, ramp_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                stop_q, stop_d;
  logic                dir_q, dir_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                boundary;
  logic                restart;
  logic                run;
  logic [STEP_W-1:0]   sl_dec;
  logic [STEP_W-1:0]   ramp_dec;
  logic [PERIOD_W:0]   p_sum;
  logic [PERIOD_W-1:0] p_up;
  logic [PERIOD_W-1:0] p_dn;

  always_comb begin
    sl_dec   = (steps_left_q != '0) ? steps_left_q - STEP_W'(1) : '0;
    ramp_dec = (ramp_q != '0) ? ramp_q - STEP_W'(1) : '0;
    p_sum    = {1'b0, period_q} + {1'b0, P_DEC};
    p_up     = (p_sum > {1'b0, P_MAX}) ? P_MAX : p_sum[PERIOD_W-1:0];
    p_dn     = (period_q >= P_DEC && (period_q - P_DEC) >= P_MIN) ? period_q - P_DEC : P_MIN;
  end

  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    ramp_d       = ramp_q;
    period_d     = period_q;
    stop_d       = stop_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    restart      = 1'b0;

    if (state_q == IDLE) begin
      if (start_i && enable_i) begin
        if (steps_i == '0) begin
          done_d = 1'b1;
        end else begin
          state_d      = ACCEL;
          dir_d        = dir_i;
          steps_left_d = steps_i;
          period_d     = P_MAX;
          ramp_d       = '0;
          stop_d       = 1'b0;
          restart      = 1'b1;
        end
      end
    end else if (!enable_i) begin
      state_d = IDLE;
      stop_d  = 1'b0;
    end else begin
      if (stop_i) begin
        stop_d = 1'b1;
      end
      if (boundary) begin
        steps_left_d = sl_dec;
        // Ramp-down is taken on stop, when already decelerating, or when the
        // remaining steps no longer cover the steps spent ramping up.
        if (sl_dec == '0 || (stop_q && ramp_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          stop_d  = 1'b0;
        end else if (stop_q || state_q == DECEL || sl_dec <= ramp_q) begin
          state_d  = DECEL;
          period_d = p_up;
          ramp_d   = ramp_dec;
        end else if (state_q == ACCEL) begin
          period_d = p_dn;
          ramp_d   = ramp_q + STEP_W'(1);
          if (p_dn == P_MIN) begin
            state_d = CRUISE;
          end
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign run = busy_d;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      steps_left_q <= '0;
      ramp_q       <= '0;
      period_q     <= '0;
      stop_q       <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      ramp_q       <= ramp_d;
      period_q     <= period_d;
      stop_q       <= stop_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  step_pulse_timer #(
    .PERIOD_W (PERIOD_W),
    .PULSE_W  (PULSE_W)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .active_i   (state_q != IDLE),
    .run_i      (run),
    .restart_i  (restart),
    .period_i   (period_q),
    .step_o     (step_o),
    .boundary_o (boundary)
  );

  assign dir_o        = dir_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign steps_left_o = steps_left_q;

endmodule
